ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Multi-cycle SPARC V8 integer multiply/divide unit in EX. Consumes the ID/EX pipeline register outputs.
//  Executes UMUL/SMUL/UDIV/SDIV and their cc forms. Drives ex_ready low to hold ID/EX while it runs.
//  Delivers result, Y and icc to the EX result mux for EX/MEM.
// PARAMETERS
//  DATA_W   32  operand/result width (only 32 supported)
//  CNT_W     5  iteration counter width (DATA_W-1 max count)
// PORTS
//  clk                 in   1   clock
//  reset               in   1   synchronous, active-high reset
//  md_op_in            in   2   op field from ID/EX
//  md_op3_in           in   6   op3 field from ID/EX
//  md_valA_in          in  32   rs1 value
//  md_opB_in           in  32   operand2 (rs2 or sign-extended simm13, already muxed)
//  md_Y_in             in  32   Y register value from ID/EX
//  md_select           out  1   comb: op==2'b10 and op3 is one of the 8 mul/div codes
//  ex_ready            out  1   comb: 1 = ID/EX may load next instruction
//  md_result_valid     out  1   1 in DONE only
//  md_result           out 32   rd write value
//  md_Y_out            out 32   new Y (upper product half)
//  md_Y_write          out  1   Y write enable, multiplies only, DONE only
//  md_icc_out          out  4   {N,Z,V,C}
//  md_icc_write        out  1   icc write enable, cc variants only, DONE only
//  md_div_zero         out  1   divisor==0 on divide, DONE only
// BEHAVIOUR
//  op3: UMUL 0A, SMUL 0B, UDIV 0E, SDIV 0F. Bit4 set = cc variant (1A,1B,1E,1F).
//  States: IDLE, RUN, FIX, DONE.
//   IDLE: md_select=1 -> latch magnitudes and signs.
//     Fast path (div by zero, or unsigned pre-overflow) -> DONE. Otherwise -> RUN with cnt=31.
//   RUN: one shift-add (mul) or restoring-subtract (div) step per cycle. At cnt==0 -> FIX. 32 cycles total.
//   FIX: apply sign correction (negate 64-bit product / quotient), then signed saturation -> DONE.
//   DONE: outputs valid for one cycle -> IDLE unconditionally.
//  ex_ready = (IDLE & ~md_select) | DONE. ID/EX advances on the DONE cycle.
//   Normal path: ex_ready low 34 cycles (IDLE + 32 RUN + FIX).
//   Fast path: ex_ready low 1 cycle.
//  Multiply
//   Full 64-bit product. md_result = P[31:0], md_Y_out = P[63:32], md_Y_write=1.
//   SMUL: operands are two's-complement.
//   Flags: N=result[31], Z=(result==0), V=0, C=0.
//  Divide
//   Dividend = {Y, valA}, 64 bits. Quotient truncates toward zero. Remainder discarded. Y not written.
//   Unsigned pre-overflow: Y >= divisor -> result 0xFFFFFFFF, V=1.
//   SDIV: magnitudes are used for the pre-overflow check. In FIX the quotient saturates:
//     positive > 0x7FFFFFFF -> 0x7FFFFFFF, V=1
//     negative > 0x80000000 -> 0x80000000, V=1
//   Flags: N=result[31], Z=(result==0), V=overflow, C=0.
//  Divisor==0: md_div_zero=1, result=0, md_icc_write=0. Trap handling belongs downstream.
//  Inputs are sampled only in IDLE. Changes to them during RUN/FIX are ignored.
//  Reset
//   All registered outputs and internal state clear to 0. State -> IDLE. ex_ready=1 while reset is asserted.
//   Reset mid-RUN aborts the operation: no DONE pulse, no Y/icc write.
//  A non-mul/div instruction in IDLE: ex_ready=1, no state change, all md_* write enables stay 0.
// STRUCTURE
//  Package sparc_ex_pkg holds:
//   - op3 localparams (OP3_UMUL..OP3_SDIVCC)
//   - typedef enum logic [1:0] md_state_t {IDLE, RUN, FIX, DONE}
//   - icc bit-index constants ICC_N/Z/V/C
//  Single module with one FSM plus a shared 64-bit accumulator/shift register for both operations.
//  No sub-module needed.
// TESTING
//  1 UMUL 0xFFFFFFFF*0xFFFFFFFF
//     -> result 0x00000001, Y 0xFFFFFFFE, Y_write=1, ex_ready low exactly 34 cycles
//  2 SMULcc -3*5
//     -> result 0xFFFFFFF1, Y 0xFFFFFFFF, icc 4'b1000, icc_write=1
//  3 UDIV Y=0 A=100 B=7
//     -> result 0x0000000E, Y_write=0, icc_write=0
//  4 UDIVcc Y=1 A=0 B=1
//     -> fast path: result 0xFFFFFFFF, icc 4'b1010, ex_ready low 1 cycle
//  5 SDIVcc Y=0xFFFFFFFF A=0xFFFFFF9C B=7
//     -> result 0xFFFFFFF2, icc 4'b1000
//     SDIVcc Y=0 A=0x80000000 B=1
//     -> saturate: result 0x7FFFFFFF, icc 4'b0010
//  6 UDIV B=0
//     -> md_div_zero=1, result 0, no writes
//     UMUL, then reset at RUN cycle 10
//     -> next cycle IDLE, all outputs 0, no result_valid

Source files
------------

// File: rtl/sparc_ex_pkg.sv
// Shared definitions for the SPARC V8 EX-stage multiply/divide unit.
//   - op3 encodings for UMUL/SMUL/UDIV/SDIV and their cc forms
//   - md_state_t: multiply/divide FSM states
//   - ICC_* bit positions within the {N,Z,V,C} icc vector
package sparc_ex_pkg;

  localparam logic [5:0] OP3_UMUL   = 6'h0A;
  localparam logic [5:0] OP3_SMUL   = 6'h0B;
  localparam logic [5:0] OP3_UDIV   = 6'h0E;
  localparam logic [5:0] OP3_SDIV   = 6'h0F;
  localparam logic [5:0] OP3_UMULCC = 6'h1A;
  localparam logic [5:0] OP3_SMULCC = 6'h1B;
  localparam logic [5:0] OP3_UDIVCC = 6'h1E;
  localparam logic [5:0] OP3_SDIVCC = 6'h1F;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_t;

  localparam int unsigned ICC_N = 3;
  localparam int unsigned ICC_Z = 2;
  localparam int unsigned ICC_V = 1;
  localparam int unsigned ICC_C = 0;

  function automatic logic is_muldiv_op3(input logic [5:0] op3);
    unique case (op3)
      OP3_UMUL, OP3_SMUL, OP3_UDIV, OP3_SDIV,
      OP3_UMULCC, OP3_SMULCC, OP3_UDIVCC, OP3_SDIVCC: is_muldiv_op3 = 1'b1;
      default:                                         is_muldiv_op3 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle SPARC V8 integer multiply/divide unit in EX.
// Executes UMUL/SMUL/UDIV/SDIV (and cc forms) on magnitudes with one shared 64-bit
// shift register, then fixes up sign/saturation. Holds ID/EX via ex_ready while busy.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   md_op_in/op3_in   instruction op/op3 fields from ID/EX
//   md_valA_in        rs1 value; md_opB_in operand2; md_Y_in current Y
//   md_select         comb: instruction is a mul/div
//   ex_ready          comb: ID/EX may load next instruction
//   md_result_valid   result valid (DONE only)
//   md_result         rd value; md_Y_out/md_Y_write new Y (multiplies)
//   md_icc_out        {N,Z,V,C}; md_icc_write for cc variants
//   md_div_zero       divide by zero flagged (DONE only)
module ex_muldiv_unit
  import sparc_ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        md_op_in,
  input  logic [5:0]        md_op3_in,
  input  logic [DATA_W-1:0] md_valA_in,
  input  logic [DATA_W-1:0] md_opB_in,
  input  logic [DATA_W-1:0] md_Y_in,
  output logic              md_select,
  output logic              ex_ready,
  output logic              md_result_valid,
  output logic [DATA_W-1:0] md_result,
  output logic [DATA_W-1:0] md_Y_out,
  output logic              md_Y_write,
  output logic [3:0]        md_icc_out,
  output logic              md_icc_write,
  output logic              md_div_zero
);

  md_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [63:0]         acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic                neg_q, neg_d;       // final result must be negated
  logic                is_div_q, is_div_d;
  logic                is_sgn_q, is_sgn_d;
  logic                is_cc_q, is_cc_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [3:0]          icc_q, icc_d;

  // Operand decode and magnitudes, only meaningful in IDLE.
  logic              in_div, in_sgn, a_neg, b_neg, y_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [63:0]       dvd, dvd_mag;
  logic              pre_ovf;

  assign md_select = (md_op_in == 2'b10) && is_muldiv_op3(md_op3_in);
  assign in_div    = md_op3_in[2];
  assign in_sgn    = md_op3_in[0];
  assign a_neg     = in_sgn & md_valA_in[DATA_W-1];
  assign b_neg     = in_sgn & md_opB_in[DATA_W-1];
  assign y_neg     = in_sgn & md_Y_in[DATA_W-1];
  assign a_mag     = a_neg ? (~md_valA_in + 1'b1) : md_valA_in;
  assign b_mag     = b_neg ? (~md_opB_in + 1'b1) : md_opB_in;
  assign dvd       = {md_Y_in, md_valA_in};
  assign dvd_mag   = y_neg ? (~dvd + 64'd1) : dvd;
  // Quotient cannot fit in 32 bits when the upper dividend half already reaches the divisor.
  assign pre_ovf   = dvd_mag[63:32] >= b_mag;

  // One iteration step for each operation.
  logic [32:0]       mul_sum;
  logic [32:0]       div_shift;
  logic              div_ge;
  logic [63:0]       mul_step, div_step;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_step  = {mul_sum, acc_q[31:1]};
  // Restoring divide: remainder in [63:32], dividend bits shift out / quotient shifts in at [31:0].
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_step  = {div_ge ? 32'(div_shift - {1'b0, opnd_q}) : div_shift[31:0],
                      acc_q[30:0], div_ge};

  // Sign correction and saturation.
  logic [63:0]       prod;
  logic [DATA_W-1:0] quo, fix_res;
  logic              fix_ovf;

  assign prod = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign quo  = acc_q[31:0];

  always_comb begin
    fix_res = quo;
    fix_ovf = 1'b0;
    if (!is_div_q) begin
      fix_res = prod[31:0];
    end else if (is_sgn_q) begin
      if (!neg_q) begin
        if (quo[31]) begin
          fix_res = 32'h7FFF_FFFF;
          fix_ovf = 1'b1;
        end
      end else if (quo > 32'h8000_0000) begin
        fix_res = 32'h8000_0000;
        fix_ovf = 1'b1;
      end else begin
        fix_res = ~quo + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    is_cc_d  = is_cc_q;
    dz_d     = dz_q;
    result_d = result_q;
    y_d      = y_q;
    icc_d    = icc_q;

    unique case (state_q)
      IDLE: begin
        if (md_select) begin
          is_div_d = in_div;
          is_sgn_d = in_sgn;
          is_cc_d  = md_op3_in[4];
          opnd_d   = b_mag;
          cnt_d    = CNT_W'(DATA_W - 1);
          dz_d     = 1'b0;
          y_d      = '0;
          icc_d    = '0;
          if (in_div) begin
            acc_d = dvd_mag;
            neg_d = y_neg ^ b_neg;
            if (md_opB_in == '0) begin
              dz_d     = 1'b1;
              result_d = '0;
              state_d  = DONE;
            end else if (pre_ovf) begin
              result_d = !in_sgn ? 32'hFFFF_FFFF :
                         (y_neg ^ b_neg) ? 32'h8000_0000 : 32'h7FFF_FFFF;
              icc_d[ICC_N] = result_d[31];
              icc_d[ICC_V] = 1'b1;
              state_d  = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            acc_d   = {32'd0, a_mag};
            neg_d   = a_neg ^ b_neg;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        result_d     = fix_res;
        y_d          = is_div_q ? '0 : prod[63:32];
        icc_d        = '0;
        icc_d[ICC_N] = fix_res[31];
        icc_d[ICC_Z] = (fix_res == '0);
        icc_d[ICC_V] = fix_ovf;
        state_d      = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      is_cc_q  <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      y_q      <= '0;
      icc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      is_cc_q  <= is_cc_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      y_q      <= y_d;
      icc_q    <= icc_d;
    end
  end

  logic done;
  assign done            = (state_q == DONE);
  assign ex_ready        = reset | ((state_q == IDLE) & ~md_select) | done;
  assign md_result_valid = done;
  assign md_result       = result_q;
  assign md_Y_out        = y_q;
  assign md_icc_out      = icc_q;
  assign md_Y_write      = done & ~is_div_q;
  assign md_icc_write    = done & is_cc_q & ~dz_q;
  assign md_div_zero     = done & dz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import sparc_ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  md_op_in;
  logic [5:0]  md_op3_in;
  logic [31:0] md_valA_in, md_opB_in, md_Y_in;
  logic        md_select, ex_ready, md_result_valid, md_Y_write, md_icc_write, md_div_zero;
  logic [31:0] md_result, md_Y_out;
  logic [3:0]  md_icc_out;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_W(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .md_op_in(md_op_in), .md_op3_in(md_op3_in),
    .md_valA_in(md_valA_in), .md_opB_in(md_opB_in), .md_Y_in(md_Y_in),
    .md_select(md_select), .ex_ready(ex_ready), .md_result_valid(md_result_valid),
    .md_result(md_result), .md_Y_out(md_Y_out), .md_Y_write(md_Y_write),
    .md_icc_out(md_icc_out), .md_icc_write(md_icc_write), .md_div_zero(md_div_zero)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] y;
    logic        y_wr;
    logic [3:0]  icc;
    logic        icc_wr;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every presented result against the head of the scoreboard.
  always @(negedge clk) begin
    if (md_result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h with no pending op", md_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", md_result, e.res);
        check("y_write", 32'(md_Y_write), 32'(e.y_wr));
        if (e.y_wr) check("y_out", md_Y_out, e.y);
        check("icc_write", 32'(md_icc_write), 32'(e.icc_wr));
        if (e.icc_wr) check("icc", 32'(md_icc_out), 32'(e.icc));
        check("div_zero", 32'(md_div_zero), 32'(e.dz));
      end
    end
  end

  // Issue one instruction, hold it until ex_ready, and check busy length.
  task automatic issue(input logic [5:0] op3, input logic [31:0] y, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e, input int lat);
    int cnt;
    md_op_in = 2'b10; md_op3_in = op3; md_Y_in = y; md_valA_in = a; md_opB_in = b;
    sb.push_back(e);
    cnt = 0;
    #1;
    while (!ex_ready && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(cnt), 32'(lat));
    md_op_in = 2'b00; md_op3_in = 6'h00;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    md_op_in = 2'b00; md_op3_in = 6'h00;
    md_valA_in = '0; md_opB_in = '0; md_Y_in = '0;
    #1;
    check("ready_in_reset", 32'(ex_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_result", md_result, 32'h0);
    check("reset_valid", 32'(md_result_valid), 32'd0);
    check("reset_icc", 32'(md_icc_out), 32'd0);

    // 1 UMUL
    issue(OP3_UMUL, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          '{res:32'h0000_0001, y:32'hFFFF_FFFE, y_wr:1'b1, icc:4'h0, icc_wr:1'b0, dz:1'b0}, 34);
    // 2 SMULcc -3*5
    issue(OP3_SMULCC, 32'h0, 32'hFFFF_FFFD, 32'd5,
          '{res:32'hFFFF_FFF1, y:32'hFFFF_FFFF, y_wr:1'b1, icc:4'b1000, icc_wr:1'b1, dz:1'b0}, 34);
    // 3 UDIV 100/7
    issue(OP3_UDIV, 32'h0, 32'd100, 32'd7,
          '{res:32'h0000_000E, y:32'h0, y_wr:1'b0, icc:4'h0, icc_wr:1'b0, dz:1'b0}, 34);
    // 4 UDIVcc pre-overflow
    issue(OP3_UDIVCC, 32'd1, 32'd0, 32'd1,
          '{res:32'hFFFF_FFFF, y:32'h0, y_wr:1'b0, icc:4'b1010, icc_wr:1'b1, dz:1'b0}, 1);
    // 5 SDIVcc -100/7 and positive saturation
    issue(OP3_SDIVCC, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7,
          '{res:32'hFFFF_FFF2, y:32'h0, y_wr:1'b0, icc:4'b1000, icc_wr:1'b1, dz:1'b0}, 34);
    issue(OP3_SDIVCC, 32'h0, 32'h8000_0000, 32'd1,
          '{res:32'h7FFF_FFFF, y:32'h0, y_wr:1'b0, icc:4'b0010, icc_wr:1'b1, dz:1'b0}, 34);
    // SMULcc zero result: Z flag
    issue(OP3_SMULCC, 32'h0, 32'h0, 32'h1234_5678,
          '{res:32'h0, y:32'h0, y_wr:1'b1, icc:4'b0100, icc_wr:1'b1, dz:1'b0}, 34);
    // 6 UDIV by zero
    issue(OP3_UDIVCC, 32'h0, 32'd55, 32'd0,
          '{res:32'h0, y:32'h0, y_wr:1'b0, icc:4'h0, icc_wr:1'b0, dz:1'b1}, 1);

    // Non-mul/div instruction: ready stays high, no result.
    md_op_in = 2'b10; md_op3_in = 6'h00; md_valA_in = 32'd3; md_opB_in = 32'd4;
    #1;
    check("nonmd_select", 32'(md_select), 32'd0);
    check("nonmd_ready", 32'(ex_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("nonmd_ready_later", 32'(ex_ready), 32'd1);
    md_op_in = 2'b00;

    // Produce nonzero registered outputs, then abort a UMUL mid-RUN with reset.
    issue(OP3_UMULCC, 32'h0, 32'd6, 32'd7,
          '{res:32'd42, y:32'h0, y_wr:1'b1, icc:4'b0000, icc_wr:1'b1, dz:1'b0}, 34);
    md_op_in = 2'b10; md_op3_in = OP3_UMUL; md_valA_in = 32'd9; md_opB_in = 32'd9;
    @(posedge clk); #1;          // now RUN cycle 1
    md_op_in = 2'b00; md_op3_in = 6'h00;
    repeat (9) @(posedge clk);   // RUN cycle 10
    #1;
    check("busy_before_reset", 32'(ex_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", 32'(ex_ready), 32'd1);
    check("abort_valid", 32'(md_result_valid), 32'd0);
    check("abort_result", md_result, 32'h0);
    check("abort_y", md_Y_out, 32'h0);
    check("abort_icc", 32'(md_icc_out), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Recovery after abort.
    issue(OP3_UDIV, 32'h0, 32'd100, 32'd7,
          '{res:32'h0000_000E, y:32'h0, y_wr:1'b0, icc:4'h0, icc_wr:1'b0, dz:1'b0}, 34);
    @(posedge clk); #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
